// File: rtl/reg_bus_ctrl_pkg.sv
// Shared types and defaults for the 74LS173 bus sequencer: command opcodes,
// FSM states and the latched command record.
package reg_bus_pkg;

    localparam int W_DEF    = 4;
    localparam int NREG_DEF = 4;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_MOVE  = 2'b01,
        OP_READ  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WRITE,
        S_CLEAR,
        S_DONE
    } state_e;

    typedef struct packed {
        op_e        op;
        logic [1:0] src;
        logic [1:0] dst;
    } cmd_t;

endpackage

// File: rtl/reg_bus_ctrl_if.sv
// Command-side handshake of the register bus sequencer: one strobed command
// in, busy/done status and read-out data back.
interface reg_bus_ctrl_if #(
    parameter int W = reg_bus_pkg::W_DEF
) ();
    import reg_bus_pkg::*;

    logic         req;
    op_e          op;
    logic [1:0]   src;
    logic [1:0]   dst;
    logic [W-1:0] din;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;
    logic         dout_valid;

    modport master (
        output req, op, src, dst, din,
        input  busy, done, dout, dout_valid
    );

    modport slave (
        input  req, op, src, dst, din,
        output busy, done, dout, dout_valid
    );

endinterface

// File: rtl/reg_bus_ctrl_sel_dec.sv
// Index-plus-enable decoder producing one active-low 2-bit control pair per
// register; an index with no matching register leaves every pair inactive.
module reg_sel_dec #(
    parameter int NREG = 4
) (
    input  logic              en,
    input  logic [1:0]        idx,
    output logic [2*NREG-1:0] field
);

    always_comb begin
        // NOTE: default assigned before the loop so every bit is written on every path; otherwise a latch is inferred.
        field = '1;
        for (int i = 0; i < NREG; i++) begin
            if (en && idx == 2'(i)) field[2*i +: 2] = 2'b00;
        end
    end

endmodule

// File: rtl/reg_bus_ctrl.sv
// Single-transfer sequencer for a bank of 74LS173 registers on one shared bus.
// All outputs are registered from the next-state decode so they change only at clock edges.
module reg_bus_ctrl
    import reg_bus_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int W    = W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    reg_bus_ctrl_if.slave     cmd,
    output logic [2*NREG-1:0] reg_g,
    output logic [2*NREG-1:0] reg_mn,
    output logic [NREG-1:0]   reg_clr,
    output logic [W-1:0]      bus_d,
    input  logic [W-1:0]      bus_q
);

    state_e            state, state_nxt;
    cmd_t              cmd_q, cmd_nxt;
    logic [W-1:0]      bus_d_nxt;
    logic [NREG-1:0]   clr_nxt;
    logic [2*NREG-1:0] g_nxt, mn_nxt;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (clr) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        bus_d_nxt = bus_d;
        clr_nxt   = '0;

        unique case (state)
            S_IDLE: begin
                if (cmd.req) begin
                    cmd_nxt.op  = cmd.op;
                    cmd_nxt.src = cmd.src;
                    cmd_nxt.dst = cmd.dst;
                    unique case (cmd.op)
                        OP_LOAD:          state_nxt = S_WRITE;
                        OP_MOVE, OP_READ: state_nxt = S_DRIVE;
                        default:          state_nxt = S_CLEAR;
                    endcase
                end
            end
            S_DRIVE:          state_nxt = (cmd_q.op == OP_READ) ? S_DONE : S_WRITE;
            S_WRITE, S_CLEAR: state_nxt = S_DONE;
            default:          state_nxt = S_IDLE;
        endcase

        // bus_d doubles as the MOVE hold register: it captures bus_q on the
        // same edge that ends DRIVE, and holds din for a LOAD.
        if (state_nxt == S_WRITE) bus_d_nxt = (state == S_IDLE) ? cmd.din : bus_q;

        for (int i = 0; i < NREG; i++) begin
            clr_nxt[i] = (state_nxt == S_CLEAR) && (cmd_nxt.dst == 2'(i));
        end
    end

    reg_sel_dec #(.NREG(NREG)) u_g_dec (
        .en    (state_nxt == S_WRITE),
        .idx   (cmd_nxt.dst),
        .field (g_nxt)
    );

    reg_sel_dec #(.NREG(NREG)) u_mn_dec (
        .en    (state_nxt == S_DRIVE),
        .idx   (cmd_nxt.src),
        .field (mn_nxt)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            cmd_q          <= '0;
            bus_d          <= '0;
            reg_g          <= '1;
            reg_mn         <= '1;
            reg_clr        <= '0;
            cmd.busy       <= 1'b0;
            cmd.done       <= 1'b0;
            cmd.dout       <= '0;
            cmd.dout_valid <= 1'b0;
        end else begin
            cmd_q          <= cmd_nxt;
            bus_d          <= bus_d_nxt;
            reg_g          <= g_nxt;
            reg_mn         <= mn_nxt;
            reg_clr        <= clr_nxt;
            cmd.busy       <= (state_nxt != S_IDLE);
            cmd.done       <= (state_nxt == S_DONE);
            cmd.dout_valid <= (state_nxt == S_DONE) && (cmd_q.op == OP_READ);
            if (state == S_DRIVE && cmd_q.op == OP_READ) cmd.dout <= bus_q;
        end
    end

endmodule

// File: doc/reg_bus_ctrl.md
# reg_bus_ctrl

Sequencer sitting directly upstream of a bank of 74LS173 4-bit tri-state registers sharing one data bus. Accepts single-transfer commands (load external data, register-to-register move, read-out, clear). Drives each register's active-low load enables (G) and output disables (M/N) plus the shared D bus. Guarantees at most one register drives the bus in any cycle.

## Interface
Parameters:
- NREG, 4, number of registers on the bus (2..4; sel fields are 2 bits)
- W, 4, data width (matches 74LS173 width)

Ports:
- clk  in  1  single clock; the registers share it
- clr  in  1  reset, synchronous, active-high
- req  in  1  command strobe; sampled only in IDLE
- op  in  2  00 LOAD din→dst, 01 MOVE src→dst, 10 READ src→dout, 11 CLEAR dst
- src  in  2  source register index
- dst  in  2  destination register index
- din  in  W  external data for LOAD
- busy  out  1  high from the cycle after acceptance until IDLE is re-entered
- done  out  1  one-cycle completion pulse
- dout  out  W  data captured by READ; held until the next READ
- dout_valid  out  1  one-cycle pulse coincident with done, for READ only
- reg_g  out  2*NREG  per-register {G2,G1}; 00 = load
- reg_mn  out  2*NREG  per-register {M,N}; 00 = drive bus
- reg_clr  out  NREG  per-register clear strobe
- bus_d  out  W  shared D input of all registers
- bus_q  in  W  shared tri-state bus readback

## Operation
- All outputs registered. Reset values: state IDLE, busy 0, done 0, dout 0, dout_valid 0, reg_g all 1, reg_mn all 1, reg_clr 0, bus_d 0.
- States: IDLE, DRIVE, WRITE, CLEAR, DONE.
- IDLE and req=1: latch op/src/dst/din. Next state:
  - LOAD → WRITE
  - MOVE → DRIVE
  - READ → DRIVE
  - CLEAR → CLEAR
- DRIVE: reg_mn[src]=00, all others 11. At the cycle-end edge, bus_q is sampled into the hold register for MOVE, or into dout for READ.
  - MOVE → WRITE
  - READ → DONE
- WRITE: reg_g[dst]=00, all reg_mn=11. bus_d = din for LOAD, hold for MOVE. → DONE.
- CLEAR: reg_clr[dst]=1 for exactly one cycle. → DONE.
- DONE: done=1; dout_valid=1 if op was READ. → IDLE.
- Invariants:
  - reg_mn has at most one pair at 00, and only in DRIVE.
  - reg_g is all 1 outside WRITE.
  - reg_clr is 0 outside CLEAR.
- No queueing: req outside IDLE (including the DONE cycle) is ignored and has no effect.
- MOVE with src==dst is legal and rewrites the same value.
- Index ≥ NREG: command accepted, no register touched, done still pulses.

## Timing
- Acceptance edge = T0.
- LOAD: WRITE T0–T1; dst loads din at T1; done in T1–T2.
- CLEAR: reg_clr high T0–T1; done in T1–T2.
- READ: DRIVE T0–T1; dout valid from T1; done and dout_valid in T1–T2.
- MOVE: DRIVE T0–T1; hold captured at T1; WRITE T1–T2; dst loads at T2; done in T2–T3.
- busy: 1 from T0 to the end of the DONE cycle; 0 in IDLE. Back-to-back commands: next req accepted at the edge ending DONE + 1, i.e. in IDLE.
- bus_d is stable for the whole WRITE cycle.
- Reset mid-operation takes effect at the next edge:
  - returns to IDLE and releases all enables/disables;
  - no done pulse, dout cleared;
  - a register already loaded stays loaded.

## Structure
- Package reg_bus_pkg: op_e (LOAD/MOVE/READ/CLEAR), state_e, default W and NREG constants.
- One sub-module, reg_sel_dec:
  - converts an index plus an enable into a per-register active-low 2-bit field;
  - used for both reg_g and reg_mn.
- Hold/dout registers and the FSM stay in reg_bus_ctrl.

## Test plan
Bench wires four 74LS173 models (clr tied to reg_clr, D to bus_d, outputs resolved onto bus_q).
- Reset, then LOAD din=4'hA dst=2 → reg2=A at T1; done in T1–T2; only reg_g[5:4]=00 during WRITE.
- Preload reg1=5, then MOVE src=1 dst=3 → reg3=5 at T2; reg_mn[3:2]=00 only in DRIVE; bus never multiply driven (checked every cycle).
- Preload reg0=C, then READ src=0 → dout=C with dout_valid=1 in T1–T2; dout holds C through a later LOAD.
- CLEAR dst=1 on reg1=F → reg1=0; reg_clr=4'b0010 for one cycle; done next cycle.
- req held high continuously with alternating ops → each command accepted only in IDLE; one done pulse per command; no overlap.
- clr asserted during a MOVE's DRIVE cycle → next cycle IDLE with all reg_mn/reg_g=1, no done, reg3 unchanged.
